// File: rtl/cache_pkg.sv
// Shared cache geometry, line/word types and the refill FSM state encoding.
// Pure declarations; no timing or flow-control behaviour of its own.
package cache_pkg;
    localparam int CACHE_DATA_WIDTH    = 32;
    localparam int CACHE_ADDRESS_WIDTH = 30;
    localparam int CACHE_BLOCK_SIZE    = 3;
    localparam int WORDS_PER_LINE      = 2**CACHE_BLOCK_SIZE;
    localparam int LINE_WIDTH          = CACHE_DATA_WIDTH*WORDS_PER_LINE;

    typedef logic [CACHE_DATA_WIDTH-1:0]    word_t;
    typedef logic [LINE_WIDTH-1:0]          line_t;
    typedef logic [CACHE_ADDRESS_WIDTH-1:0] word_addr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } fill_state_t;
endpackage

// File: rtl/line_assembler.sv
// Line buffer: one registered word slot per index, cleared in one cycle.
// Writes land on the next edge; no backpressure, the caller sequences writes.
module line_assembler #(
    parameter int DATA_WIDTH = 32,
    parameter int BLOCK_SIZE = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clr_i,
    input  logic                                 wr_en_i,
    input  logic [BLOCK_SIZE-1:0]                wr_idx_i,
    input  logic [DATA_WIDTH-1:0]                wr_data_i,
    output logic [(DATA_WIDTH<<BLOCK_SIZE)-1:0]  line_o
);
    logic [(DATA_WIDTH<<BLOCK_SIZE)-1:0] line_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q <= '0;
        end else if (clr_i) begin
            line_q <= '0;
        end else if (wr_en_i) begin
            line_q[wr_idx_i*DATA_WIDTH +: DATA_WIDTH] <= wr_data_i;
        end
    end

    assign line_o = line_q;
endmodule

// File: rtl/line_fill_unit.sv
// Refill engine: fetches every word of a missed line with pipelined reads, then pulses fill_valid.
// N+2 cycles from accept at full rate; mem_gnt low holds mem_req/mem_addr, outstanding reads capped.
module line_fill_unit
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDRESS_WIDTH   = 30,
    parameter int BLOCK_SIZE      = 3,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 fill_req,
    input  logic [ADDRESS_WIDTH-1:0]             fill_addr,
    output logic                                 fill_busy,
    output logic                                 fill_valid,
    output logic [(DATA_WIDTH<<BLOCK_SIZE)-1:0]  fill_line,
    output logic [ADDRESS_WIDTH-1:0]             fill_tag_addr,
    output logic                                 mem_req,
    output logic [ADDRESS_WIDTH-1:0]             mem_addr,
    input  logic                                 mem_gnt,
    input  logic                                 mem_rvalid,
    input  logic [DATA_WIDTH-1:0]                mem_rdata
);
    localparam int                     N         = 2**BLOCK_SIZE;
    localparam int                     CW        = BLOCK_SIZE + 1;
    localparam logic [CW-1:0]          N_C       = CW'(N);
    localparam logic [CW-1:0]          LAST_C    = CW'(N - 1);
    localparam logic [CW-1:0]          MAX_OUT_C = CW'(MAX_OUTSTANDING);
    localparam logic [ADDRESS_WIDTH-1:0] OFS_MASK = ADDRESS_WIDTH'(N - 1);

    fill_state_t               state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]  base_q, base_d;
    logic [CW-1:0]             issue_cnt_q, issue_cnt_d;
    logic [CW-1:0]             recv_cnt_q, recv_cnt_d;
    logic [CW-1:0]             outstanding;
    logic                      grant;
    logic                      capture;
    logic                      clr_line;

    assign outstanding = issue_cnt_q - recv_cnt_q;
    assign mem_req     = (state_q == FETCH) && (issue_cnt_q < N_C) && (outstanding < MAX_OUT_C);
    // Base has its offset bits cleared, so OR-ing the index never carries out of the line.
    assign mem_addr    = base_q | ADDRESS_WIDTH'(issue_cnt_q[BLOCK_SIZE-1:0]);
    assign grant       = mem_req && mem_gnt;
    assign capture     = (state_q == FETCH) && mem_rvalid && (recv_cnt_q < issue_cnt_q);

    assign fill_busy     = (state_q != IDLE);
    assign fill_valid    = (state_q == DONE);
    assign fill_tag_addr = base_q;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        clr_line    = 1'b0;
        case (state_q)
            IDLE: begin
                if (fill_req) begin
                    state_d     = FETCH;
                    base_d      = fill_addr & ~OFS_MASK;
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                    clr_line    = 1'b1;
                end
            end
            FETCH: begin
                if (grant) begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                end
                if (capture) begin
                    recv_cnt_d = recv_cnt_q + 1'b1;
                    if (recv_cnt_q == LAST_C) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
        end
    end

    line_assembler #(
        .DATA_WIDTH (DATA_WIDTH),
        .BLOCK_SIZE (BLOCK_SIZE)
    ) u_line_assembler (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (clr_line),
        .wr_en_i   (capture),
        .wr_idx_i  (recv_cnt_q[BLOCK_SIZE-1:0]),
        .wr_data_i (mem_rdata),
        .line_o    (fill_line)
    );

    // Read data with nothing in flight means the memory and this block disagree on ordering.
    assert property (@(posedge clk) disable iff (rst)
        (state_q == FETCH && mem_rvalid) |-> (recv_cnt_q < issue_cnt_q))
        else $error("line_fill_unit: mem_rvalid with no outstanding request");
endmodule

// File: tb/tb_line_fill_unit.sv
// Directed bench for line_fill_unit with an in-order, configurable-latency memory responder.
module tb_line_fill_unit;
    logic          clk = 1'b0;
    logic          rst;
    logic          fill_req;
    logic [29:0]   fill_addr;
    logic          fill_busy;
    logic          fill_valid;
    logic [255:0]  fill_line;
    logic [29:0]   fill_tag_addr;
    logic          mem_req;
    logic [29:0]   mem_addr;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [31:0]   mem_rdata;

    int checks   = 0;
    int failures = 0;

    // Stimulus-side knobs (written only by the main sequence).
    int          mem_lat    = 1;
    logic [7:0]  stall_mask = 8'h00;
    logic        stray_en   = 1'b0;
    logic [29:0] exp_base   = '0;

    // Responder-side observations (written only by the responder).
    logic [29:0] q_addr[$];
    int          q_due[$];
    logic [29:0] req_log[$];
    int          cyc       = 0;
    logic [3:0]  gidx      = '0;
    int          stall_ctr = 0;
    int          max_out   = 0;
    int          stall_cyc = 0;
    int          stall_bad = 0;

    always #5 clk = ~clk;

    line_fill_unit dut (
        .clk           (clk),
        .rst           (rst),
        .fill_req      (fill_req),
        .fill_addr     (fill_addr),
        .fill_busy     (fill_busy),
        .fill_valid    (fill_valid),
        .fill_line     (fill_line),
        .fill_tag_addr (fill_tag_addr),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_gnt       (mem_gnt),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata)
    );

    // Memory: returns data mem_lat cycles after each grant, in order; stalls the
    // grant for 3 cycles in front of each word selected by stall_mask.
    initial begin
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                q_addr.delete();
                q_due.delete();
                mem_rvalid = 1'b0;
                mem_gnt    = 1'b0;
                gidx       = '0;
                stall_ctr  = 0;
            end else begin
                cyc++;
                if (stray_en) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = 32'hDEAD_BEEF;
                end else if (q_addr.size() > 0 && q_due[0] <= cyc) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = 32'hA000_0000 + 32'(q_addr[0]);
                    void'(q_addr.pop_front());
                    void'(q_due.pop_front());
                end else begin
                    mem_rvalid = 1'b0;
                    mem_rdata  = '0;
                end
                if (mem_req && gidx < 4'd8 && stall_mask[gidx[2:0]] && stall_ctr < 3) begin
                    mem_gnt = 1'b0;
                    stall_ctr++;
                end else begin
                    mem_gnt = 1'b1;
                end
            end
            @(negedge clk);
            if (!rst) begin
                if (!fill_busy) begin
                    gidx      = '0;
                    stall_ctr = 0;
                    max_out   = 0;
                    stall_cyc = 0;
                    stall_bad = 0;
                end
                if (mem_req && !mem_gnt) begin
                    stall_cyc++;
                    if (mem_addr !== exp_base + 30'(gidx)) stall_bad++;
                end
                if (mem_req && mem_gnt) begin
                    req_log.push_back(mem_addr);
                    q_addr.push_back(mem_addr);
                    q_due.push_back(cyc + mem_lat);
                    gidx      = gidx + 4'd1;
                    stall_ctr = 0;
                end
                if (q_addr.size() + int'(mem_rvalid) > max_out) max_out = q_addr.size() + int'(mem_rvalid);
            end
        end
    end

    task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic check_zero(input string name);
        chk({name, "_busy"},  {255'd0, fill_busy},  256'd0);
        chk({name, "_valid"}, {255'd0, fill_valid}, 256'd0);
        chk({name, "_req"},   {255'd0, mem_req},    256'd0);
        chk({name, "_addr"},  {226'd0, mem_addr},   256'd0);
        chk({name, "_line"},  fill_line,            256'd0);
        chk({name, "_tag"},   {226'd0, fill_tag_addr}, 256'd0);
    endtask

    task automatic check_line(input string name, input logic [29:0] base);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_w%0d", name, i), {224'd0, fill_line[i*32 +: 32]},
                {224'd0, 32'hA000_0000 + 32'(base) + 32'(i)});
        end
    endtask

    // Call away from a clock edge with the DUT in IDLE; returns at the negedge
    // of the cycle after DONE.
    task automatic run_fill(input string name, input logic [29:0] addr, input int lat,
                            input int exp_lat, input int exp_idle, input int exp_max,
                            input int exp_stall, input bit toggle);
        int rel = 0, vcnt = 0, vrel = 0, busy_low = 0, idle_req = 0, g = 0;
        int log_start;
        mem_lat   = lat;
        exp_base  = addr & ~30'h7;
        log_start = req_log.size();
        fill_addr = addr;
        fill_req  = 1'b1;
        @(posedge clk);
        #1;
        fill_req = 1'b0;
        while (vcnt == 0 && rel < 200) begin
            @(negedge clk);
            rel++;
            if (rel == 1) begin
                chk({name, "_cleared"}, fill_line, 256'd0);
                chk({name, "_tag_new"}, {226'd0, fill_tag_addr}, {226'd0, exp_base});
            end
            if (!fill_busy) busy_low++;
            if (mem_req && mem_gnt) g++;
            else if (!mem_req && g < 8 && !fill_valid) idle_req++;
            if (fill_valid) begin
                vcnt++;
                vrel = rel;
            end
            if (toggle) fill_req = fill_valid ? 1'b1 : !fill_req;
        end
        chk({name, "_latency"}, 256'(vrel), 256'(exp_lat));
        chk({name, "_busy_low"}, 256'(busy_low), 256'd0);
        chk({name, "_req_gaps"}, 256'(idle_req), 256'(exp_idle));
        chk({name, "_max_out"}, 256'(max_out), 256'(exp_max));
        chk({name, "_stall_cyc"}, 256'(stall_cyc), 256'(exp_stall));
        chk({name, "_stall_hold_bad"}, 256'(stall_bad), 256'd0);
        chk({name, "_tag"}, {226'd0, fill_tag_addr}, {226'd0, exp_base});
        check_line(name, exp_base);
        chk({name, "_nreq"}, 256'(req_log.size() - log_start), 256'd8);
        for (int i = 0; i < 8; i++) begin
            if (log_start + i < req_log.size())
                chk($sformatf("%s_addr%0d", name, i), {226'd0, req_log[log_start + i]},
                    {226'd0, exp_base + 30'(i)});
        end
        @(negedge clk);
        fill_req = 1'b0;
        chk({name, "_pulse_end"}, {255'd0, fill_valid}, 256'd0);
        chk({name, "_idle_after"}, {255'd0, fill_busy}, 256'd0);
    endtask

    initial begin
        int rv_seen;
        rst       = 1'b1;
        fill_req  = 1'b0;
        fill_addr = '0;

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Basic fill, grant every cycle, data one cycle after grant.
        run_fill("basic", 30'h123, 1, 10, 0, 2, 0, 1'b0);

        // Three-cycle grant stalls in front of words 0 and 5.
        stall_mask = 8'b0010_0001;
        run_fill("stall", 30'h345, 1, 16, 0, 2, 6, 1'b0);
        stall_mask = 8'h00;

        // Slow memory: request stream throttled at 4 in flight.
        run_fill("outst", 30'h4008, 6, 18, 3, 4, 0, 1'b0);

        // Grant+rvalid coincide; fill_req toggled through FETCH and DONE.
        run_fill("simul", 30'h2A7, 2, 11, 0, 3, 0, 1'b1);
        @(negedge clk);
        chk("simul_no_restart", {255'd0, fill_busy}, 256'd0);

        // Reset after three words, then stray return data.
        mem_lat   = 1;
        fill_addr = 30'h777;
        fill_req  = 1'b1;
        @(posedge clk);
        #1;
        fill_req = 1'b0;
        rv_seen  = 0;
        for (int i = 0; i < 50 && rv_seen < 3; i++) begin
            @(negedge clk);
            if (mem_rvalid) rv_seen++;
        end
        chk("midrst_words_seen", 256'(rv_seen), 256'd3);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_zero("midrst_async");
        @(negedge clk);
        rst      = 1'b0;
        stray_en = 1'b1;
        @(negedge clk);
        chk("stray1_busy", {255'd0, fill_busy}, 256'd0);
        chk("stray1_rv",   {255'd0, mem_rvalid}, 256'd1);
        stray_en = 1'b0;
        @(negedge clk);
        chk("stray2_busy", {255'd0, fill_busy}, 256'd0);
        @(negedge clk);
        check_zero("after_stray");

        run_fill("fresh", 30'h200, 1, 10, 0, 2, 0, 1'b0);

        // Back-to-back: request in the first IDLE cycle; old line must still be held.
        check_line("held", 30'h200);
        chk("held_tag", {226'd0, fill_tag_addr}, {226'd0, 30'h200});
        run_fill("b2b", 30'h3F9, 1, 10, 0, 2, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/line_fill_unit.md
Name: line_fill_unit

Overview:
- Memory-side refill engine between the direct-mapped data cache and the word-wide data memory.
- On a miss, the cache hands over a word address.
- The block fetches every word of the enclosing line, using a request/grant/return-valid protocol with pipelined requests.
- It assembles the words into one line and presents the line to the cache with a single-cycle valid pulse.

Parameters:
- DATA_WIDTH, 32, bits per word.
- ADDRESS_WIDTH, 30, word-address width.
- BLOCK_SIZE, 3, log2 of words per line (8 words, so the line is 256 bits).
- MAX_OUTSTANDING, 4, maximum number of accepted requests whose data has not yet returned (1..2**BLOCK_SIZE).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- fill_req  in  1  cache requests a refill; sampled only in IDLE.
- fill_addr  in  ADDRESS_WIDTH  word address of the miss; its low BLOCK_SIZE bits are ignored.
- fill_busy  out  1  high whenever state is not IDLE.
- fill_valid  out  1  one-cycle pulse: fill_line is complete.
- fill_line  out  DATA_WIDTH*2**BLOCK_SIZE  assembled line; word i sits at bits [i*DATA_WIDTH +: DATA_WIDTH].
- fill_tag_addr  out  ADDRESS_WIDTH  line base address (low bits zero) of the held line.
- mem_req  out  1  word read request.
- mem_addr  out  ADDRESS_WIDTH  word address of the request.
- mem_gnt  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  read data valid; returns in request order, at least 1 cycle after grant.
- mem_rdata  in  DATA_WIDTH  read data.

Behaviour:
- Reset (asynchronous, active-high, effective immediately):
  - fill_busy, fill_valid, mem_req = 0; mem_addr, fill_line, fill_tag_addr = 0.
  - Counters = 0, state = IDLE.
  - Reset mid-fill abandons the fill. Data arriving after reset deasserts is ignored.
- States: IDLE, FETCH, DONE.
- IDLE:
  - fill_req=1 at edge k latches base = fill_addr with its low BLOCK_SIZE bits cleared.
  - The same edge clears issue_cnt, recv_cnt and fill_line, then moves to FETCH.
  - mem_req is first high in cycle k+1.
- FETCH, issue side:
  - mem_req = (issue_cnt < N) && (issue_cnt - recv_cnt < MAX_OUTSTANDING), where N = 2**BLOCK_SIZE.
  - mem_addr = base | issue_cnt[BLOCK_SIZE-1:0]. It never carries out of the line, so there is no wrap handling.
  - A request is accepted on mem_req && mem_gnt, which increments issue_cnt.
  - mem_req and mem_addr stay stable until the grant.
- FETCH, return side:
  - mem_rvalid while recv_cnt < issue_cnt writes mem_rdata into word recv_cnt of fill_line and increments recv_cnt.
  - A grant and an rvalid in the same cycle are both honoured; the outstanding count is unchanged.
  - mem_rvalid with nothing outstanding is ignored and flagged by an assertion.
- Counter widths are BLOCK_SIZE+1 bits.
- FETCH exits when the Nth word is captured. That edge moves to DONE.
- DONE:
  - Lasts exactly one cycle with fill_valid=1, fill_line = full line, fill_tag_addr = base. Then IDLE.
  - fill_line and fill_tag_addr hold their values until the next fill_req is accepted.
- fill_req in FETCH or DONE is ignored; the cache must hold it until fill_busy=0.
- Minimum latency with gnt always 1 and 1-cycle rvalid: fill_valid rises N+2 cycles after the accepting edge.
- mem_req is never asserted in IDLE or DONE.

Decomposition:
- Package cache_pkg:
  - Constants WORDS_PER_LINE = 2**BLOCK_SIZE and LINE_WIDTH = DATA_WIDTH*WORDS_PER_LINE.
  - Typedef fill_state_t enum {IDLE, FETCH, DONE}.
  - Line and word typedefs, shared with the cache.
- Sub-module line_assembler:
  - Registered line buffer with synchronous clear and a word-indexed write enable.
  - Holds fill_line.
- FSM, counters and request logic stay in the top module.

Test Plan:
- Basic fill: fill_addr=0x00000123, gnt=1, rvalid 1 cycle after grant, rdata = 0xA0000000+addr.
  - mem_addr must be 0x120..0x127.
  - fill_valid pulses exactly once, at N+2 cycles.
  - fill_line word i = 0xA0000120+i; fill_tag_addr=0x120.
- Grant stalls: gnt low for 3 cycles before words 0 and 5 → mem_req and mem_addr held steady through the stall; line still correct.
- Outstanding limit: MAX_OUTSTANDING=4, gnt=1, rvalid delayed by 6 cycles → mem_req drops after 4 grants and resumes as data returns; no more than 4 words are ever outstanding.
- Simultaneous events: gnt and rvalid in the same cycle, plus fill_req toggling during FETCH and DONE → no extra fill starts; fill_busy stays 1 until DONE ends.
- Reset mid-fill: assert rst after 3 words, then release, then inject 2 stray rvalids → every output is 0 and state is IDLE.
  - A fresh fill to 0x200 then completes with no stale words.
- Back-to-back fills: fill_req asserted in the cycle fill_busy drops → the second fill starts with the line cleared, and the previous fill_line held until that accepting edge.
